// File: rtl/eth_rx.sv
// eth_rx: 10BASE-T Manchester receiver. Recovers bits from mid-bit edges, hunts for the
// preamble/SFD, writes payload bytes to a BRAM port and reports length, FCS and alignment.
module eth_rx #(
    parameter int CLKS_PER_BIT = 8,
    parameter int MIN_PREAMBLE = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_p,
    output logic        bram_wr_en,
    output logic [9:0]  bram_wr_addr,
    output logic [7:0]  bram_wr_data,
    output logic        rx_busy,
    output logic        rx_done,
    output logic [10:0] rx_len,
    output logic        rx_crc_ok,
    output logic        rx_err,
    output logic [1:0]  dbg_state
);
    localparam int TW = $clog2(2 * CLKS_PER_BIT + 1);
    localparam int PW = $clog2(MIN_PREAMBLE + 1);
    localparam logic [TW-1:0] T_SAT = TW'(2 * CLKS_PER_BIT);
    localparam logic [TW-1:0] T_MID = TW'((3 * CLKS_PER_BIT) / 4);
    localparam logic [TW-1:0] T_EOC = TW'((3 * CLKS_PER_BIT) / 2);
    localparam logic [PW-1:0] P_MIN = PW'(MIN_PREAMBLE);
    localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;
    localparam logic [10:0] LEN_MAX     = 11'd1024;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic          sync1_q, sync2_q, level_q;
    logic [TW-1:0] timer_q;
    logic          prev_bit_q;
    logic [PW-1:0] pre_cnt_q;
    logic [6:0]    shift_q;
    logic [2:0]    bit_cnt_q;
    logic [10:0]   byte_cnt_q;
    logic          ovf_q;
    logic [31:0]   crc_q;

    logic        edge_det, mid_edge, eoc, bit_val, sfd;
    logic [7:0]  byte_next;
    logic [31:0] crc_next;

    // Edges closer than 3/4 bit to the last mid-bit edge are cell boundaries.
    assign bit_val   = sync2_q;
    assign edge_det  = sync2_q ^ level_q;
    assign mid_edge  = edge_det && ((state_q == IDLE) || (timer_q >= T_MID));
    assign eoc       = (timer_q >= T_EOC);
    assign sfd       = (state_q == PREAMBLE) && mid_edge && bit_val && prev_bit_q &&
                       (pre_cnt_q >= P_MIN);
    assign byte_next = {bit_val, shift_q};
    assign crc_next  = {crc_q[30:0], 1'b0} ^ ((bit_val ^ crc_q[31]) ? CRC_POLY : 32'h0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            timer_q <= '0;
            state_q <= IDLE;
        end else begin
            sync1_q <= rx_p;
            sync2_q <= sync1_q;
            level_q <= sync2_q;
            state_q <= state_d;
            if (mid_edge) begin
                timer_q <= '0;
            end else if (timer_q != T_SAT) begin
                timer_q <= timer_q + TW'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rx_done   = 1'b0;
        rx_busy   = 1'b0;
        dbg_state = state_q;
        unique case (state_q)
            IDLE: begin
                if (edge_det) state_d = PREAMBLE;
            end
            PREAMBLE: begin
                rx_busy = 1'b1;
                if (mid_edge) begin
                    if (sfd) state_d = DATA;
                end else if (eoc) begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                rx_busy = 1'b1;
                if (!mid_edge && eoc) state_d = DONE;
            end
            DONE: begin
                rx_done = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // bram_wr_en is a single-cycle strobe with no backpressure: addr/data are valid
    // only in the cycle it is high, and the sink must accept every strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_bit_q   <= 1'b0;
            pre_cnt_q    <= '0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            ovf_q        <= 1'b0;
            crc_q        <= '0;
            bram_wr_en   <= 1'b0;
            bram_wr_addr <= '0;
            bram_wr_data <= '0;
            rx_len       <= '0;
            rx_crc_ok    <= 1'b0;
            rx_err       <= 1'b0;
        end else begin
            bram_wr_en <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (edge_det) begin
                        prev_bit_q <= bit_val;
                        pre_cnt_q  <= PW'(1);
                    end
                end
                PREAMBLE: begin
                    if (mid_edge) begin
                        prev_bit_q <= bit_val;
                        if (sfd) begin
                            crc_q      <= '1;
                            bit_cnt_q  <= '0;
                            byte_cnt_q <= '0;
                            ovf_q      <= 1'b0;
                        end else if (bit_val != prev_bit_q) begin
                            if (pre_cnt_q != P_MIN) pre_cnt_q <= pre_cnt_q + PW'(1);
                        end else begin
                            pre_cnt_q <= PW'(1);
                        end
                    end
                end
                DATA: begin
                    if (mid_edge) begin
                        shift_q   <= byte_next[7:1];
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        crc_q     <= crc_next;
                        if (bit_cnt_q == 3'd7) begin
                            if (byte_cnt_q != LEN_MAX) begin
                                bram_wr_en   <= 1'b1;
                                bram_wr_addr <= byte_cnt_q[9:0];
                                bram_wr_data <= byte_next;
                                byte_cnt_q   <= byte_cnt_q + 11'd1;
                            end else begin
                                ovf_q <= 1'b1;
                            end
                        end
                    end else if (eoc) begin
                        // Results are latched here so they are valid during DONE and held after.
                        rx_len    <= byte_cnt_q;
                        rx_crc_ok <= (crc_q == CRC_RESIDUE) && (byte_cnt_q >= 11'd4);
                        rx_err    <= ovf_q || (bit_cnt_q != 3'd0);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_eth_rx.sv
// tb_eth_rx: directed Manchester frames against a bit-level receive model; every BRAM
// write and every rx_done is scored against the model's expected queues.
module tb_eth_rx;
    localparam int CPB  = 8;
    localparam int MINP = 16;
    localparam logic [31:0] POLY    = 32'h04C11DB7;
    localparam logic [31:0] RESIDUE = 32'hC704DD7B;

    typedef struct packed {
        logic [10:0] len;
        logic        crc_ok;
        logic        err;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_p = 1'b0;
    logic        bram_wr_en;
    logic [9:0]  bram_wr_addr;
    logic [7:0]  bram_wr_data;
    logic        rx_busy;
    logic        rx_done;
    logic [10:0] rx_len;
    logic        rx_crc_ok;
    logic        rx_err;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail = 0;
    int wr_seen = 0;
    int done_seen = 0;
    logic [17:0] exp_q[$];
    res_t        done_q[$];
    logic        frame_bits[$];
    logic [17:0] cmp_e;
    res_t        cmp_r;

    eth_rx #(.CLKS_PER_BIT(CPB), .MIN_PREAMBLE(MINP)) dut (
        .clk(clk), .rst_n(rst_n), .rx_p(rx_p),
        .bram_wr_en(bram_wr_en), .bram_wr_addr(bram_wr_addr), .bram_wr_data(bram_wr_data),
        .rx_busy(rx_busy), .rx_done(rx_done), .rx_len(rx_len),
        .rx_crc_ok(rx_crc_ok), .rx_err(rx_err), .dbg_state(dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic b);
        return {c[30:0], 1'b0} ^ ((b ^ c[31]) ? POLY : 32'h0);
    endfunction

    function automatic logic [7:0] frame_byte(input int i);
        logic [7:0] b;
        for (int j = 0; j < 8; j++) b[j] = frame_bits[8 * i + j];
        return b;
    endfunction

    // Payload byte i = i mod 256, FCS sent x^31 first, optional corrupted bit and dribble.
    task automatic build_frame(input int n_payload, input bit add_fcs, input int flip_byte,
                               input int n_dribble);
        logic [31:0] c;
        logic [7:0]  b;
        frame_bits.delete();
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n_payload; i++) begin
            b = 8'(i);
            for (int j = 0; j < 8; j++) begin
                c = crc_step(c, b[j]);
                frame_bits.push_back(b[j] ^ ((i == flip_byte) && (j == 0)));
            end
        end
        if (add_fcs) for (int k = 31; k >= 0; k--) frame_bits.push_back(~c[k]);
        for (int d = 0; d < n_dribble; d++) frame_bits.push_back(~d[0]);
    endtask

    // Receiver model: whole bytes are written (first 1024), CRC over every bit.
    task automatic model_expect();
        int nbits, nbytes;
        logic [31:0] c;
        res_t r;
        nbits  = frame_bits.size();
        nbytes = nbits / 8;
        for (int i = 0; i < nbytes && i < 1024; i++) exp_q.push_back({10'(i), frame_byte(i)});
        c = 32'hFFFFFFFF;
        for (int i = 0; i < nbits; i++) c = crc_step(c, frame_bits[i]);
        r.len    = (nbytes > 1024) ? 11'd1024 : 11'(nbytes);
        r.crc_ok = (c == RESIDUE) && (nbytes >= 4);
        r.err    = (nbytes > 1024) || ((nbits % 8) != 0);
        done_q.push_back(r);
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_bit(input logic b);
        rx_p = ~b;
        repeat (CPB / 2) @(negedge clk);
        rx_p = b;
        repeat (CPB / 2) @(negedge clk);
    endtask

    task automatic send_frame(input int n_bits, input bit with_tail);
        logic [7:0] pb;
        for (int k = 0; k < 8; k++) begin
            pb = (k == 7) ? 8'hD5 : 8'h55;
            for (int j = 0; j < 8; j++) send_bit(pb[j]);
        end
        for (int i = 0; i < n_bits; i++) send_bit(frame_bits[i]);
        if (with_tail) begin
            rx_p = 1'b1;
            repeat (2 * CPB) @(negedge clk);
            rx_p = 1'b0;
            repeat (48) @(negedge clk);
        end
    endtask

    task automatic run_frame(input string tag, input int exp_len, input logic exp_ok,
                             input logic exp_err, input int exp_wr);
        int w0, d0;
        w0 = wr_seen;
        d0 = done_seen;
        model_expect();
        send_frame(frame_bits.size(), 1'b1);
        check({tag, "_done_count"}, done_seen - d0, 1);
        check({tag, "_wr_count"}, wr_seen - w0, exp_wr);
        check({tag, "_len"}, 32'(rx_len), exp_len);
        check({tag, "_crc_ok"}, 32'(rx_crc_ok), 32'(exp_ok));
        check({tag, "_err"}, 32'(rx_err), 32'(exp_err));
        check({tag, "_wr_drained"}, exp_q.size(), 0);
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (bram_wr_en) begin
                wr_seen++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr %0d data 0x%02h, required no write",
                             bram_wr_addr, bram_wr_data);
                end else begin
                    cmp_e = exp_q.pop_front();
                    check("wr_addr", 32'(bram_wr_addr), 32'(cmp_e[17:8]));
                    check("wr_data", 32'(bram_wr_data), 32'(cmp_e[7:0]));
                end
            end
            if (rx_done) begin
                done_seen++;
                if (done_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: rx_len %0d, required no rx_done", rx_len);
                end else begin
                    cmp_r = done_q.pop_front();
                    check("done_len", 32'(rx_len), 32'(cmp_r.len));
                    check("done_crc_ok", 32'(rx_crc_ok), 32'(cmp_r.crc_ok));
                    check("done_err", 32'(rx_err), 32'(cmp_r.err));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int w0, d0, k;
        logic [31:0] c, c0;
        logic [7:0]  pin [9];

        repeat (4) @(negedge clk);
        check("rst_wr_en", 32'(bram_wr_en), 0);
        check("rst_wr_addr", 32'(bram_wr_addr), 0);
        check("rst_wr_data", 32'(bram_wr_data), 0);
        check("rst_busy", 32'(rx_busy), 0);
        check("rst_done", 32'(rx_done), 0);
        check("rst_len", 32'(rx_len), 0);
        check("rst_crc_ok", 32'(rx_crc_ok), 0);
        check("rst_err", 32'(rx_err), 0);
        check("rst_state", 32'(dbg_state), 0);

        // Model pins: CRC-32 of "123456789" in shift-left form, then the FCS residue.
        pin = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 9; i++) for (int j = 0; j < 8; j++) c = crc_step(c, pin[i][j]);
        check("model_crc_123456789", c, 32'h9B63D02C);
        c0 = c;
        for (int b = 31; b >= 0; b--) c = crc_step(c, ~c0[b]);
        check("model_residue", c, RESIDUE);

        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Reset in the middle of byte 20: bytes 0..19 written, no rx_done.
        build_frame(60, 1'b1, -1, 0);
        for (int i = 0; i < 20; i++) exp_q.push_back({10'(i), frame_byte(i)});
        w0 = wr_seen;
        d0 = done_seen;
        send_frame(20 * 8 + 4, 1'b0);
        @(negedge clk);
        check("abort_busy_before", 32'(rx_busy), 1);
        check("abort_state_before", 32'(dbg_state), 2);
        rst_n = 1'b0;
        rx_p  = 1'b0;
        @(negedge clk);
        check("abort_busy_in_reset", 32'(rx_busy), 0);
        check("abort_state_in_reset", 32'(dbg_state), 0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_wr_count", wr_seen - w0, 20);
        check("abort_no_done", done_seen - d0, 0);
        check("abort_wr_drained", exp_q.size(), 0);

        // First full frame after reset: 60 payload + FCS.
        build_frame(60, 1'b1, -1, 0);
        run_frame("good64", 64, 1'b1, 1'b0, 64);

        // Minimum length that may pass the CRC: FCS of an empty payload only.
        build_frame(0, 1'b1, -1, 0);
        run_frame("fcs_only", 4, 1'b1, 1'b0, 4);

        // Bit 0 of byte 10 flipped after the FCS was computed.
        build_frame(28, 1'b1, 10, 0);
        run_frame("corrupt", 32, 1'b0, 1'b0, 32);

        // Link pulse on the idle line: silent rejection.
        w0 = wr_seen;
        d0 = done_seen;
        rx_p = 1'b1;
        repeat (4) @(negedge clk);
        rx_p = 1'b0;
        check("link_busy_high", 32'(rx_busy), 1);
        k = 0;
        while (rx_busy && k < 14) begin
            @(negedge clk);
            k++;
        end
        check("link_busy_low", 32'(rx_busy), 0);
        repeat (30) @(negedge clk);
        check("link_no_write", wr_seen - w0, 0);
        check("link_no_done", done_seen - d0, 0);
        check("link_len_held", 32'(rx_len), 32);

        // Good 64-byte frame followed by 3 dribble bits.
        build_frame(60, 1'b1, -1, 3);
        run_frame("align", 64, 1'b0, 1'b1, 64);

        // 1026-byte payload: writes stop at address 1023, overflow flagged.
        build_frame(1026, 1'b0, -1, 0);
        run_frame("overflow", 1024, 1'b0, 1'b1, 1024);
        repeat (30) @(negedge clk);
        check("overflow_len_held", 32'(rx_len), 1024);
        check("overflow_err_held", 32'(rx_err), 1);

        check("done_q_drained", done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
